axi4_burst_master: RTL and testbench
====================================

Name: axi4_burst_master

Overview:
Single-outstanding AXI4 master that turns a simple command/stream interface into AXI4 INCR bursts toward the team's AXI4 memory slave (DATA_WIDTH 32, ADDR_WIDTH 16, 1024-word memory).
- Sits directly upstream of that slave. Test sequences and on-chip clients issue read/write bursts here instead of driving raw AXI channels.
- Handles one command at a time: address phase, data beats, response, then a done pulse with the aggregated response.

Parameters:
DATA_WIDTH, 32, data bus width (WDATA/RDATA/stream data)
ADDR_WIDTH, 16, byte address width (AWADDR/ARADDR/cmd_addr)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, accepts command
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_len  in  8  beats minus one (AXI LEN)
cmd_size  in  3  AXI SIZE (log2 bytes per beat)
wr_valid  in  1  write data beat available
wr_ready  out  1  write data beat consumed
wr_data  in  DATA_WIDTH  write data
rd_valid  out  1  read data beat valid
rd_ready  in  1  consumer accepts read beat
rd_data  out  DATA_WIDTH  read data
rd_last  out  1  last read beat
done  out  1  one-cycle pulse, command complete
done_resp  out  2  final response (write: BRESP; read: worst RRESP)
AWVALID/AWREADY  out/in  1  write address handshake
AWADDR  out  ADDR_WIDTH; AWLEN out 8; AWSIZE out 3; AWBURST out 2
WVALID/WREADY  out/in  1; WDATA out DATA_WIDTH; WLAST out 1
BVALID in 1; BREADY out 1; BRESP in 2
ARVALID/ARREADY  out/in  1; ARADDR out ADDR_WIDTH; ARLEN out 8; ARSIZE out 3; ARBURST out 2
RVALID in 1; RREADY out 1; RDATA in DATA_WIDTH; RRESP in 2; RLAST in 1

Behaviour:
- Reset (async, ARESET=1): state IDLE, cmd_ready=1, AWVALID=ARVALID=0, BREADY=0, done=0, done_resp=00, beat counter=0, AWADDR/ARADDR/AWLEN/ARLEN/AWSIZE/ARSIZE=0. AWBURST/ARBURST constant 2'b01 (INCR).
- Reset mid-burst: abandon the transaction immediately. No done pulse. Return to IDLE.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: register addr/len/size into AW* or AR* fields, clear beat_cnt and err_acc, set cmd_ready=0.
  - Assert AWVALID (write) or ARVALID (read) on the next cycle; go to AW or AR.
- AW: hold AWVALID and address fields stable until AWREADY. On AWVALID&AWREADY: AWVALID<=0, go to W.
- W:
  - Combinational passthrough: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data, WLAST=(beat_cnt==len). All gated with state==W; 0 outside W.
  - Each WVALID&WREADY increments beat_cnt (8-bit).
  - Beat with WLAST=1: go to B.
  - Gaps in wr_valid are legal; the master never asserts WVALID without wr_valid.
- B:
  - BREADY=1 (combinational, state==B).
  - On BVALID: done_resp<=BRESP, done<=1 for one cycle, go to IDLE.
  - BVALID sampled only in B; the slave may already have BVALID high on entry.
- AR: same as AW using ARVALID/ARREADY; go to R.
- R:
  - Passthrough: rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=RLAST. All gated with state==R.
  - Per accepted beat: beat_cnt++, err_acc<=max(err_acc,RRESP).
  - On accepted beat with RLAST=1: done_resp<=max(err_acc,RRESP), done pulse, go to IDLE.
  - RLAST arriving before beat_cnt==len, or beat_cnt==len without RLAST: force done_resp=2'b10 (SLVERR) at completion.
- Latency: cmd accept to AWVALID/ARVALID = 1 cycle. Last handshake (B or last R) to done = 1 cycle. cmd_ready reasserts the cycle after done.
- No 4KB-boundary or range checking in the master; commands are issued as given, and the slave's error response propagates to done_resp.
- cmd_valid while busy is ignored (cmd_ready=0).

Test Plan:
- Write cmd addr=0x0010 len=0 size=2, wr_data=0xDEADBEEF -> AWADDR=0x0010 AWLEN=0 AWBURST=01. One W beat with WLAST=1. done pulse one cycle, done_resp=00.
- Write burst addr=0x0100 len=3 size=2, data 0x11..0x44, wr_valid low for 2 cycles between beats 2 and 3 -> exactly 4 W handshakes, WLAST only on beat 4, done_resp=00.
- Read burst addr=0x0100 len=3 size=2, rd_ready toggled 1/0 -> rd_data 0x11,0x22,0x33,0x44 in order, rd_last only on beat 4, done_resp=00.
- Write then read addr=0x1000 (word 1024, out of range) len=0 -> write done_resp=10; read rd_data=0, done_resp=10.
- Read crossing 4KB (addr=0x0FF8 len=3 size=2) -> all RRESP=10, done_resp=10.
- ARESET pulsed during beat 2 of a 4-beat write -> WVALID/AWVALID=0 immediately, no done, cmd_ready=1. A following single write completes with done_resp=00.

Source files
------------

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-outstanding AXI4 master that turns a command plus
// write/read beat streams into INCR bursts, then reports one aggregated response.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high except during the done cycle
// AW     | write address presented, waiting for AWREADY
// W      | write beats passed through from wr_* to W channel
// B      | waiting for write response
// AR     | read address presented, waiting for ARREADY
// R      | read beats passed through from R channel to rd_*
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] beat_cnt;
  logic [1:0] err_acc;
  logic       len_err;
  logic       cmd_fire;
  logic       w_fire;
  logic       r_fire;
  logic [1:0] rresp_max;
  logic       len_bad;

  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign w_fire    = (state == S_W) && wr_valid && WREADY;
  assign r_fire    = (state == S_R) && RVALID && rd_ready;
  assign rresp_max = (RRESP > err_acc) ? RRESP : err_acc;
  // A beat count that disagrees with RLAST in either direction poisons the response.
  assign len_bad   = RLAST ? (beat_cnt != ARLEN) : (beat_cnt == ARLEN);

  // State register; reset abandons any burst in flight without a done pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the combinational channel passthroughs.
  always_comb begin
    state_nxt = state;
    // Held low during the done cycle so a new command lands the cycle after it.
    cmd_ready = (state == S_IDLE) && !done;
    WVALID    = 1'b0;
    wr_ready  = 1'b0;
    WDATA     = '0;
    WLAST     = 1'b0;
    BREADY    = 1'b0;
    rd_valid  = 1'b0;
    RREADY    = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    case (state)
      S_IDLE: if (cmd_fire) state_nxt = cmd_write ? S_AW : S_AR;
      S_AW:   if (AWVALID && AWREADY) state_nxt = S_W;
      S_W: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WDATA    = wr_data;
        WLAST    = (beat_cnt == AWLEN);
        if (w_fire && WLAST) state_nxt = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = S_IDLE;
      end
      S_AR:   if (ARVALID && ARREADY) state_nxt = S_R;
      S_R: begin
        rd_valid = RVALID;
        RREADY   = rd_ready;
        rd_data  = RDATA;
        rd_last  = RLAST;
        if (r_fire && RLAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address-phase registers, beat counting, response aggregation and done pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      AWLEN     <= '0;
      AWSIZE    <= '0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      ARLEN     <= '0;
      ARSIZE    <= '0;
      beat_cnt  <= '0;
      err_acc   <= '0;
      len_err   <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            beat_cnt <= '0;
            err_acc  <= '0;
            len_err  <= 1'b0;
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              AWLEN   <= cmd_len;
              AWSIZE  <= cmd_size;
              AWVALID <= 1'b1;
            end else begin
              ARADDR  <= cmd_addr;
              ARLEN   <= cmd_len;
              ARSIZE  <= cmd_size;
              ARVALID <= 1'b1;
            end
          end
        end
        S_AW: if (AWVALID && AWREADY) AWVALID <= 1'b0;
        S_AR: if (ARVALID && ARREADY) ARVALID <= 1'b0;
        S_W:  if (w_fire) beat_cnt <= beat_cnt + 8'd1;
        S_B: begin
          if (BVALID) begin
            done_resp <= BRESP;
            done      <= 1'b1;
          end
        end
        S_R: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            err_acc  <= rresp_max;
            if (len_bad) len_err <= 1'b1;
            if (RLAST) begin
              done      <= 1'b1;
              done_resp <= (len_err || len_bad) ? 2'b10 : rresp_max;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: a small AXI4 memory slave model, stream sources,
// and a scoreboard monitor that pops expected beats/responses on every handshake.
`timescale 1ns/1ps
module tb_axi4_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  done_resp;
  logic        AWVALID, AWREADY;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WVALID, WREADY, WLAST;
  logic [31:0] WDATA;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        RVALID, RREADY, RLAST;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [15:0] addr; logic [7:0] len; logic [2:0] size; } addr_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;
  typedef struct { int gap; logic [31:0] data; } wsrc_t;

  addr_t      exp_aw[$];
  addr_t      exp_ar[$];
  beat_t      exp_w[$];
  beat_t      exp_rd[$];
  logic [1:0] exp_done[$];
  wsrc_t      wr_q[$];

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_target = 0;
  int w_seen = 0;
  logic prev_done = 1'b0;
  logic rd_mode = 1'b0;
  logic slv_early = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  // ---------------- memory slave model ----------------
  logic [31:0] mem [0:1023];
  int          s_state;
  logic [15:0] s_addr;
  logic [7:0]  s_len;
  logic [2:0]  s_size;
  int          s_beat;
  logic        s_err, s_werr;
  logic        s_awv, s_arv, s_aw_hs, s_ar_hs, s_w_hs, s_b_hs, s_r_hs, s_wlast;
  logic [15:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [31:0] s_wdata;

  function automatic logic crosses(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz);
    int first, last;
    first = int'(a);
    last  = first + (int'(l) << sz);
    return (first >> 12) != (last >> 12);
  endfunction

  task automatic drive_r();
    logic [31:0] av;
    logic        e;
    av = 32'(int'(s_addr) + (s_beat << s_size));
    e  = s_err || (av >= 32'h1000);
    RDATA = e ? 32'h0 : mem[av[11:2]];
    RRESP = e ? 2'b10 : 2'b00;
    RLAST = slv_early ? (s_beat == int'(s_len) - 1) : (s_beat == int'(s_len));
    RVALID = 1'b1;
  endtask

  initial begin
    logic [31:0] av;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    s_state = 0; s_beat = 0; s_err = 0; s_werr = 0;
    s_addr = 0; s_len = 0; s_size = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    forever begin
      @(negedge ACLK);
      s_awv = AWVALID; s_arv = ARVALID;
      s_aw_hs = AWVALID && AWREADY;
      s_ar_hs = ARVALID && ARREADY;
      s_w_hs  = WVALID && WREADY;
      s_b_hs  = BVALID && BREADY;
      s_r_hs  = RVALID && RREADY;
      s_awaddr = AWADDR; s_awlen = AWLEN; s_awsize = AWSIZE;
      s_araddr = ARADDR; s_arlen = ARLEN; s_arsize = ARSIZE;
      s_wdata = WDATA; s_wlast = WLAST;
      @(posedge ACLK); #1;
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        s_state = 0;
      end else begin
        AWREADY = s_awv && !s_aw_hs && (s_state == 0);
        ARREADY = s_arv && !s_ar_hs && (s_state == 0);
        case (s_state)
          0: begin
            if (s_aw_hs) begin
              s_addr = s_awaddr; s_len = s_awlen; s_size = s_awsize;
              s_beat = 0; s_werr = 0; s_err = crosses(s_awaddr, s_awlen, s_awsize);
              s_state = 1; WREADY = 1;
            end else if (s_ar_hs) begin
              s_addr = s_araddr; s_len = s_arlen; s_size = s_arsize;
              s_beat = 0; s_err = crosses(s_araddr, s_arlen, s_arsize);
              s_state = 3; drive_r();
            end
          end
          1: begin
            if (s_w_hs) begin
              av = 32'(int'(s_addr) + (s_beat << s_size));
              if (s_err || av >= 32'h1000) s_werr = 1;
              else mem[av[11:2]] = s_wdata;
              s_beat++;
              if (s_wlast) begin
                WREADY = 0; BVALID = 1;
                BRESP = (s_err || s_werr) ? 2'b10 : 2'b00;
                s_state = 2;
              end
            end
          end
          2: if (s_b_hs) begin BVALID = 0; s_state = 0; end
          3: begin
            if (s_r_hs) begin
              if (RLAST) begin RVALID = 0; RLAST = 0; s_state = 0; end
              else begin s_beat++; drive_r(); end
            end
          end
          default: s_state = 0;
        endcase
      end
    end
  end

  // ---------------- write stream source ----------------
  initial begin
    logic  acc;
    wsrc_t e;
    wr_valid = 0; wr_data = 0;
    forever begin
      @(negedge ACLK);
      acc = wr_valid && wr_ready;
      @(posedge ACLK); #1;
      if (acc && wr_q.size() > 0) void'(wr_q.pop_front());
      if (wr_q.size() == 0) wr_valid = 0;
      else begin
        e = wr_q.pop_front();
        if (e.gap > 0) begin
          e.gap = e.gap - 1;
          wr_valid = 0;
        end else begin
          wr_valid = 1;
          wr_data = e.data;
        end
        wr_q.push_front(e);
      end
    end
  end

  // ---------------- read consumer ----------------
  initial begin
    rd_ready = 1;
    forever begin
      @(posedge ACLK); #1;
      rd_ready = rd_mode ? ~rd_ready : 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    addr_t a;
    beat_t b;
    logic [1:0] r;
    forever begin
      @(negedge ACLK);
      if (ARESET) prev_done = 1'b0;
      else begin
        if (AWVALID && AWREADY) begin
          if (exp_aw.size() == 0) unexpected("aw_handshake");
          else begin
            a = exp_aw.pop_front();
            chk("awaddr", AWADDR, a.addr);
            chk("awlen", AWLEN, a.len);
            chk("awsize", AWSIZE, a.size);
            chk("awburst", AWBURST, 2'b01);
          end
        end
        if (ARVALID && ARREADY) begin
          if (exp_ar.size() == 0) unexpected("ar_handshake");
          else begin
            a = exp_ar.pop_front();
            chk("araddr", ARADDR, a.addr);
            chk("arlen", ARLEN, a.len);
            chk("arsize", ARSIZE, a.size);
            chk("arburst", ARBURST, 2'b01);
          end
        end
        if (WVALID && WREADY) begin
          w_seen++;
          if (exp_w.size() == 0) unexpected("w_beat");
          else begin
            b = exp_w.pop_front();
            chk("wdata", WDATA, b.data);
            chk("wlast", WLAST, b.last);
          end
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) unexpected("rd_beat");
          else begin
            b = exp_rd.pop_front();
            chk("rd_data", rd_data, b.data);
            chk("rd_last", rd_last, b.last);
          end
        end
        if (prev_done) chk("cmd_ready_after_done", cmd_ready, 1);
        if (done) begin
          chk("done_one_cycle", prev_done, 0);
          chk("cmd_ready_during_done", cmd_ready, 0);
          if (exp_done.size() == 0) unexpected("done_pulse");
          else begin
            r = exp_done.pop_front();
            chk("done_resp", done_resp, r);
          end
          done_seen++;
        end
        prev_done = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_w(input int gap, input logic [31:0] d, input logic last);
    wr_q.push_back('{gap, d});
    exp_w.push_back('{d, last});
  endtask

  task automatic push_rd(input logic [31:0] d, input logic last);
    exp_rd.push_back('{d, last});
  endtask

  task automatic issue(input logic w, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size);
    int n;
    logic ok;
    @(posedge ACLK); #1;
    cmd_write = w; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_valid = 1;
    ok = 0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge ACLK);
      ok = cmd_ready;
      n++;
    end
    if (!ok) begin total++; bad++; $display("FAIL cmd_accept: got timeout want cmd_ready"); end
    @(posedge ACLK); #1;
    cmd_valid = 0;
    @(negedge ACLK);
    chk("addr_valid_latency", w ? AWVALID : ARVALID, 1);
    chk("busy_cmd_ready", cmd_ready, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < done_target && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    if (done_seen < done_target) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d want %0d", done_seen, done_target);
    end
  endtask

  task automatic run_cmd(input logic w, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] resp);
    if (w) exp_aw.push_back('{addr, len, size});
    else   exp_ar.push_back('{addr, len, size});
    exp_done.push_back(resp);
    done_target++;
    issue(w, addr, len, size);
    wait_done();
  endtask

  initial begin
    int base, n, saved;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, saved;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
    ARESET = 1;
    repeat (3) @(posedge ACLK);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_done", done, 0);
    chk("rst_done_resp", done_resp, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_arlen", ARLEN, 0);
    chk("rst_arburst", ARBURST, 2'b01);
    ARESET = 0;

    // single-beat write
    push_w(0, 32'hDEADBEEF, 1);
    run_cmd(1, 16'h0010, 8'd0, 3'd2, 2'b00);

    // 4-beat write with a two-cycle gap before beat 3
    push_w(0, 32'h11, 0);
    push_w(0, 32'h22, 0);
    push_w(2, 32'h33, 0);
    push_w(0, 32'h44, 1);
    run_cmd(1, 16'h0100, 8'd3, 3'd2, 2'b00);

    // 4-beat read with a stalling consumer
    rd_mode = 1;
    push_rd(32'h11, 0); push_rd(32'h22, 0); push_rd(32'h33, 0); push_rd(32'h44, 1);
    run_cmd(0, 16'h0100, 8'd3, 3'd2, 2'b00);
    rd_mode = 0;

    // out-of-range write then read
    push_w(0, 32'hCAFEF00D, 1);
    run_cmd(1, 16'h1000, 8'd0, 3'd2, 2'b10);
    push_rd(32'h0, 1);
    run_cmd(0, 16'h1000, 8'd0, 3'd2, 2'b10);

    // read crossing a 4KB boundary
    push_rd(32'h0, 0); push_rd(32'h0, 0); push_rd(32'h0, 0); push_rd(32'h0, 1);
    run_cmd(0, 16'h0FF8, 8'd3, 3'd2, 2'b10);

    // slave ends the burst one beat early: response forced to SLVERR
    slv_early = 1;
    push_rd(32'h11, 0); push_rd(32'h22, 0); push_rd(32'h33, 1);
    run_cmd(0, 16'h0100, 8'd3, 3'd2, 2'b10);
    slv_early = 0;

    // reset while beat 2 of a 4-beat write is presented
    base = w_seen;
    saved = done_seen;
    exp_aw.push_back('{16'h0200, 8'd3, 3'd2});
    for (int i = 0; i < 4; i++) push_w(0, 32'hA0 + i, i == 3);
    issue(1, 16'h0200, 8'd3, 3'd2);
    n = 0;
    while (w_seen < base + 1 && n < 100) begin @(negedge ACLK); n++; end
    chk("abort_beat1_seen", w_seen, base + 1);
    @(posedge ACLK); #2;
    chk("abort_beat2_presented", WVALID, 1);
    ARESET = 1;
    #1;
    chk("abort_wvalid", WVALID, 0);
    chk("abort_awvalid", AWVALID, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    wr_q.delete();
    exp_w.delete();
    @(posedge ACLK);
    @(posedge ACLK); #3;
    ARESET = 0;
    repeat (5) @(posedge ACLK);
    chk("abort_no_done", done_seen, saved);

    // recovery write, then read back both earlier data words
    push_w(0, 32'h5A5A5A5A, 1);
    run_cmd(1, 16'h0020, 8'd0, 3'd2, 2'b00);
    push_rd(32'h5A5A5A5A, 1);
    run_cmd(0, 16'h0020, 8'd0, 3'd2, 2'b00);
    push_rd(32'hDEADBEEF, 1);
    run_cmd(0, 16'h0010, 8'd0, 3'd2, 2'b00);

    repeat (3) @(posedge ACLK);
    chk("left_exp_w", exp_w.size(), 0);
    chk("left_exp_rd", exp_rd.size(), 0);
    chk("left_exp_done", exp_done.size(), 0);
    chk("left_exp_aw", exp_aw.size(), 0);
    chk("left_exp_ar", exp_ar.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
